dpram_pingpong_ctrl: RTL and testbench



---
 rtl/dpram_pingpong_ctrl.sv | 101 ++++++++++
 tb/tb_dpram_pingpong_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dpram_pingpong_ctrl.sv
// dpram_pingpong_ctrl: two-bank ping-pong controller driving both ports of a 64x8 true dual-port RAM.
// Optional early bank close via in_last when PINGPONG_PARTIAL_FLUSH_EN is defined.
module dpram_pingpong_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef PINGPONG_PARTIAL_FLUSH_EN
  input  logic                  in_last,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            bank_full,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic                  ram_we_a,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);
  localparam int OW = ADDR_WIDTH - 1;
  logic                  wr_bank, rd_bank;
  logic [OW-1:0]         wr_ptr, rd_ptr, last_off0, last_off1;
  logic                  inflight, inflight_last;
  logic [1:0]            occ, bf_n;
  logic [DATA_WIDTH-1:0] h_data, t_data;
  logic                  h_last, t_last;
  logic                  accept, close, issue, rd_done, pop, push;
  assign in_ready = rst_n && !bank_full[wr_bank];
  assign accept   = in_valid && in_ready;
`ifdef PINGPONG_PARTIAL_FLUSH_EN
  assign close    = accept && (in_last || &wr_ptr);
`else
  assign close    = accept && &wr_ptr;
`endif
  assign out_valid = |occ;
  assign out_data  = h_data;
  assign out_last  = h_last;
  assign pop       = out_valid && out_ready;
  assign push      = inflight;
  // FIFO credit: never issue a read that would find no room when it lands
  assign issue   = bank_full[rd_bank] && ({1'b0, occ} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
  assign rd_done = issue && (rd_ptr == (rd_bank ? last_off1 : last_off0));
  assign ram_we_a   = accept;
  assign ram_addr_a = {wr_bank, wr_ptr};
  assign ram_data_a = accept ? in_data : '0;
  assign ram_addr_b = {rd_bank, rd_ptr};
  assign ram_data_b = '0;
  assign ram_we_b   = 1'b0;
  always_comb begin
    bf_n = bank_full;
    if (close) bf_n[wr_bank] = 1'b1;
    if (rd_done) bf_n[rd_bank] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full     <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      last_off0     <= '0;
      last_off1     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      occ           <= '0;
      h_data        <= '0;
      t_data        <= '0;
      h_last        <= 1'b0;
      t_last        <= 1'b0;
    end else begin
      bank_full <= bf_n;
      if (accept) wr_ptr <= close ? '0 : wr_ptr + 1'b1;
      if (close) begin
        wr_bank <= ~wr_bank;
        if (wr_bank) last_off1 <= wr_ptr;
        else last_off0 <= wr_ptr;
      end
      if (issue) rd_ptr <= rd_done ? '0 : rd_ptr + 1'b1;
      if (rd_done) rd_bank <= ~rd_bank;
      inflight      <= issue;
      inflight_last <= rd_done;
      if (pop || (push && occ == 2'd0)) begin
        h_data <= (pop && occ == 2'd2) ? t_data : ram_q_b;
        h_last <= (pop && occ == 2'd2) ? t_last : inflight_last;
      end
      if (push && (occ == 2'd2 || (occ == 2'd1 && !pop))) begin
        t_data <= ram_q_b;
        t_last <= inflight_last;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_dpram_pingpong_ctrl.sv
// tb_dpram_pingpong_ctrl: scoreboard bench with a behavioural RAM; checks order, last flags, addresses and stability.
module tb_dpram_pingpong_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, out_last, ram_we_a, ram_we_b;
  logic [7:0] out_data, ram_data_a, ram_data_b, ram_q_b;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic [1:0] bank_full;
  logic [7:0] mem [64];
  logic [8:0] src_q [$];
  logic [8:0] sb [$];
  logic [8:0] e, h;
  int         n_chk = 0, n_err = 0, acc_cnt = 0, out_cnt = 0, a0, o0;
  bit         rnd = 0, or_fixed = 0, hold = 0, hl, exp_last;
  logic [7:0] hd;
  logic       wbank = 1'b0;
  logic [4:0] wptr = '0;
  logic [5:0] last_wa = '0;

  always #5 clk = ~clk;

  dpram_pingpong_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef PINGPONG_PARTIAL_FLUSH_EN
    .in_last(in_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .bank_full(bank_full), .ram_data_a(ram_data_a), .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a),
    .ram_data_b(ram_data_b), .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
  );

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    in_valid = src_q.size() != 0;
    if (in_valid) begin
      h = src_q[0];
      in_data = h[7:0];
      in_last = h[8];
    end
    out_ready = rnd ? 1'($urandom_range(0, 1)) : or_fixed;
  end

  always @(negedge clk) if (rst_n) begin
    if (in_valid && in_ready) begin
      exp_last = in_last || (wptr == 5'd31);
      chk("wr_en", 32'(ram_we_a), 1);
      chk("wr_addr", 32'(ram_addr_a), 32'({wbank, wptr}));
      chk("wr_data", 32'(ram_data_a), 32'(in_data));
      sb.push_back({exp_last, in_data});
      void'(src_q.pop_front());
      last_wa = ram_addr_a;
      acc_cnt++;
      if (exp_last) begin
        wbank = ~wbank;
        wptr = '0;
      end else wptr = wptr + 5'd1;
      chk("no_rdw", 32'(bank_full[ram_addr_b[5]] && ram_addr_a == ram_addr_b), 0);
    end else chk("wr_idle", 32'(ram_we_a), 0);
    if (hold) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'(hd));
      chk("hold_last", 32'(out_last), 32'(hl));
    end
    hold = out_valid && !out_ready;
    hd = out_data;
    hl = out_last;
    if (out_valid && out_ready) begin
      out_cnt++;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e[7:0]));
        chk("out_last", 32'(out_last), 32'(e[8]));
      end
    end
  end

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_cnt < n && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("acc_wait", 32'(acc_cnt >= n), 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((src_q.size() != 0 || sb.size() != 0) && t < 5000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("drain", 32'(src_q.size() + sb.size()), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_bank_full", 32'(bank_full), 0);
    chk("rst_we_a", 32'(ram_we_a), 0);
    chk("rst_addr_a", 32'(ram_addr_a), 0);
    chk("rst_addr_b", 32'(ram_addr_b), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    chk("post_rst_bank_full", 32'(bank_full), 0);
    or_fixed = 1;
    for (int i = 0; i < 32; i++) src_q.push_back({1'b0, 8'(i)});
    wait_acc(32);
    @(negedge clk);
    chk("fill_bank_full", 32'(bank_full), 32'h1);
    chk("fill_valid_w", 32'(out_valid), 0);
    @(negedge clk);
    chk("fill_valid_w1", 32'(out_valid), 0);
    @(negedge clk);
    chk("fill_valid_w2", 32'(out_valid), 1);
    wait_drain();
    chk("single_out_cnt", 32'(out_cnt), 32);
    o0 = out_cnt;
    for (int i = 0; i < 64; i++) src_q.push_back({1'b0, 8'(i + 100)});
    wait_drain();
    chk("b2b_out_cnt", 32'(out_cnt - o0), 64);
    or_fixed = 0;
    a0 = acc_cnt;
    o0 = out_cnt;
    for (int i = 0; i < 96; i++) src_q.push_back({1'b0, 8'($urandom_range(0, 255))});
    repeat (100) @(negedge clk);
    #1;
    chk("bp_acc", 32'(acc_cnt - a0), 64);
    chk("bp_bank_full", 32'(bank_full), 32'h3);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    or_fixed = 1;
    wait_drain();
    chk("bp_out_cnt", 32'(out_cnt - o0), 96);
    o0 = out_cnt;
    rnd = 1;
    for (int i = 0; i < 256; i++) src_q.push_back({1'b0, 8'($urandom_range(0, 255))});
    wait_drain();
    rnd = 0;
    chk("rnd_out_cnt", 32'(out_cnt - o0), 256);
`ifdef PINGPONG_PARTIAL_FLUSH_EN
    o0 = out_cnt;
    for (int i = 0; i < 5; i++) src_q.push_back({i == 4, 8'(i + 8'h50)});
    src_q.push_back({1'b1, 8'hAA});
    wait_drain();
    chk("flush_next_addr", 32'(last_wa), 32);
    chk("flush_out_cnt", 32'(out_cnt - o0), 6);
`endif
    repeat (5) @(negedge clk);
    chk("end_bank_full", 32'(bank_full), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
